in_port_fifo: RTL and testbench
===============================

// Module: in_port_fifo
// PURPOSE
//  Input-side peripheral for the pipelined 8-bit CPU: the counterpart of the output port.
//  An external producer pushes bytes over a valid/ready handshake into a small FIFO.
//  The CPU drains the FIFO one byte per IN instruction via I_Port.
//  Raises a held interrupt request (to int_sig) when data arrives; the CPU ISR acknowledges it.
// PARAMETERS
//  DATA_W   8   byte width of port data
//  DEPTH    4   FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  rstn       in   1       synchronous, active-low reset
//  ext_data   in   DATA_W  producer byte
//  ext_valid  in   1       producer has a byte on ext_data
//  ext_ready  out  1       FIFO can accept; = !full
//  cpu_rd     in   1       IN instruction in EX this cycle; pop one entry
//  cpu_data   out  DATA_W  to CPU I_Port; head entry, or last popped byte when empty
//  empty      out  1       no entries
//  full       out  1       count == DEPTH
//  int_en     in   1       interrupt enable from CPU control
//  int_ack    in   1       one-cycle ack from CPU when the ISR is entered
//  int_req    out  1       to CPU int_sig; level, held until ack
//  ovf        out  1       sticky: ext_valid seen while full; cleared only by reset
// BEHAVIOUR
//  Reset (rstn=0 at edge): pointers=0, count=0, empty=1, full=0, ext_ready=1,
//   cpu_data=0, int_req=0, ovf=0, IRQ FSM=IDLE. Reset wins over every other input.
//  Push: ext_valid & ext_ready at an edge writes ext_data at wr_ptr; wr_ptr++ mod DEPTH.
//  Pop: cpu_rd & !empty at an edge; rd_ptr++ mod DEPTH; popped byte goes into last_data.
//  cpu_rd while empty is ignored: no pointer move, no error, cpu_data holds last_data.
//  cpu_data: mem[rd_ptr] when !empty (combinational); otherwise last_data.
//   Latency: a byte pushed at edge N is on cpu_data after edge N if the FIFO was empty.
//  Simultaneous push+pop, 0<count<DEPTH: both happen, count unchanged.
//  Push+pop when empty: only the push happens. When full: ext_ready=0, so only the pop happens.
//  Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
//  ovf sets at the edge where ext_valid=1 and full=1; the byte is dropped.
//  IRQ FSM (int_req registered, = state==PEND):
//   IDLE -> PEND   when int_en & count_next != 0
//   PEND -> WAIT   on int_ack (ack has priority over everything else in PEND)
//   PEND -> IDLE   if FIFO drains to empty before ack (request withdrawn)
//   WAIT -> IDLE   when FIFO is empty after the edge (ISR drained it); re-arms
//   int_en=0 forces the state to IDLE at the next edge.
//   int_ack outside PEND is ignored.
// STRUCTURE
//  cpu_io_pkg: DATA_W default, irq_state_t enum {IRQ_IDLE, IRQ_PEND, IRQ_WAIT}.
//   Shared with the output port block.
//  Sub-module sync_fifo (DEPTH, DATA_W): storage, pointers, count, full/empty, last_data.
//   in_port_fifo wraps it with ovf and the IRQ FSM.
// TESTING
//  1 Reset: after rstn low 1 cycle, check empty=1, ext_ready=1, cpu_data=00, int_req=0, ovf=0.
//  2 Push A5 with int_en=1: cpu_data=A5 and int_req=1 after that edge. Pulse int_ack:
//    int_req=0. cpu_rd: empty=1, cpu_data stays A5. Next push re-raises int_req.
//  3 Push 11,22,33,44 (full=1, ext_ready=0), then push 55 -> ovf=1, 55 dropped.
//    Four pops read 11,22,33,44 in order.
//  4 Wrap: push 4 / pop 4 twice, then simultaneous push 66 + pop each cycle for 6 cycles.
//    FIFO order is preserved and count is constant.
//  5 cpu_rd while empty: pointers unchanged; a later push of 77 is read back as 77.
//  6 Reset mid-operation, with 3 entries and int_req=1: everything returns to reset values
//    the next cycle. Full program: CPU LDM/IN loop reads 01,02 via I_Port, then
//    ADD gives R0=03 and O_Port=03.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// rtl/cpu_io_pkg.sv - shared types and defaults for the CPU I/O port blocks
package cpu_io_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_PEND,
        IRQ_WAIT
    } irq_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - small synchronous FIFO with first-word fall-through and last-popped hold
module sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [$clog2(DEPTH):0] count_next
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [DATA_W-1:0] last_data;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    // When drained, the CPU keeps seeing the byte it popped last.
    assign rd_data = empty ? last_data : mem[rd_ptr];

    // Occupancy after the coming edge; the IRQ logic looks ahead with this.
    always_comb begin
        count_next = count;
        if (do_wr && !do_rd) begin
            count_next = count + ONE;
        end else if (!do_wr && do_rd) begin
            count_next = count - ONE;
        end
    end

    // Pointers, occupancy and the last popped byte.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_data <= '0;
        end else begin
            count <= count_next;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_data <= mem[rd_ptr];
            end
        end
    end

    // Storage array; contents are only observable through valid pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/in_port_fifo.sv
// rtl/in_port_fifo.sv - CPU input port: producer FIFO with overflow flag and held interrupt request
module in_port_fifo #(
    parameter int DATA_W = cpu_io_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] ext_data,
    input  logic              ext_valid,
    output logic              ext_ready,
    input  logic              cpu_rd,
    output logic [DATA_W-1:0] cpu_data,
    output logic              empty,
    output logic              full,
    input  logic              int_en,
    input  logic              int_ack,
    output logic              int_req,
    output logic              ovf
);

    import cpu_io_pkg::*;

    irq_state_t              state;
    irq_state_t              state_next;
    logic [$clog2(DEPTH):0]  count_next;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .wr_en      (ext_valid),
        .wr_data    (ext_data),
        .rd_en      (cpu_rd),
        .rd_data    (cpu_data),
        .empty      (empty),
        .full       (full),
        .count_next (count_next)
    );

    assign ext_ready = ~full;
    assign int_req   = (state == IRQ_PEND);

    // Sticky overflow: a byte offered while full is dropped and remembered until reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ovf <= 1'b0;
        end else if (ext_valid && full) begin
            ovf <= 1'b1;
        end
    end

    // IRQ state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IRQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // IRQ next state: raise on data, wait for the ISR to drain after ack, withdraw if drained early.
    always_comb begin
        state_next = state;
        if (!int_en) begin
            state_next = IRQ_IDLE;
        end else begin
            case (state)
                IRQ_IDLE: if (count_next != '0) state_next = IRQ_PEND;
                IRQ_PEND: begin
                    if (int_ack) begin
                        state_next = IRQ_WAIT;
                    end else if (count_next == '0) begin
                        state_next = IRQ_IDLE;
                    end
                end
                IRQ_WAIT: if (count_next == '0) state_next = IRQ_IDLE;
                default:  state_next = IRQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_in_port_fifo.sv
// tb/tb_in_port_fifo.sv - self-checking bench for in_port_fifo
module tb_in_port_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] ext_data;
    logic       ext_valid;
    logic       ext_ready;
    logic       cpu_rd;
    logic [7:0] cpu_data;
    logic       empty;
    logic       full;
    logic       int_en;
    logic       int_ack;
    logic       int_req;
    logic       ovf;

    int n_cmp = 0;
    int n_err = 0;

    in_port_fifo #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ext_data  (ext_data),
        .ext_valid (ext_valid),
        .ext_ready (ext_ready),
        .cpu_rd    (cpu_rd),
        .cpu_data  (cpu_data),
        .empty     (empty),
        .full      (full),
        .int_en    (int_en),
        .int_ack   (int_ack),
        .int_req   (int_req),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a byte queue, the last byte handed to the CPU, and the request/acked flags.
    logic [7:0] q[$];
    logic [7:0] m_last;
    logic       m_ovf;
    logic       m_irq;
    logic       m_acked;
    logic       started = 1'b0;
    logic       m_push;
    logic       m_pop;
    int         n_after;

    always @(posedge clk) begin
        if (!rstn) begin
            q.delete();
            m_last  = 8'h00;
            m_ovf   = 1'b0;
            m_irq   = 1'b0;
            m_acked = 1'b0;
            started = 1'b1;
        end else begin
            m_push = ext_valid && (q.size() < DEPTH);
            m_pop  = cpu_rd && (q.size() > 0);
            if (ext_valid && q.size() == DEPTH) m_ovf = 1'b1;
            if (m_pop) m_last = q.pop_front();
            if (m_push) q.push_back(ext_data);
            n_after = q.size();
            if (!int_en) begin
                m_irq   = 1'b0;
                m_acked = 1'b0;
            end else if (m_irq) begin
                if (int_ack) begin
                    m_irq   = 1'b0;
                    m_acked = 1'b1;
                end else if (n_after == 0) begin
                    m_irq = 1'b0;
                end
            end else if (m_acked) begin
                if (n_after == 0) m_acked = 1'b0;
            end else if (n_after != 0) begin
                m_irq = 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("m_empty",     {31'd0, empty},     {31'd0, q.size() == 0});
            chk("m_full",      {31'd0, full},      {31'd0, q.size() == DEPTH});
            chk("m_ext_ready", {31'd0, ext_ready}, {31'd0, q.size() != DEPTH});
            chk("m_cpu_data",  {24'd0, cpu_data},  {24'd0, (q.size() != 0) ? q[0] : m_last});
            chk("m_int_req",   {31'd0, int_req},   {31'd0, m_irq});
            chk("m_ovf",       {31'd0, ovf},       {31'd0, m_ovf});
        end
    end

    // One clock: apply inputs now, return 2 time units after the edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic rd, input logic ack);
        ext_valid = v;
        ext_data  = d;
        cpu_rd    = rd;
        int_ack   = ack;
        @(posedge clk);
        #2;
    endtask

    logic [7:0] exp_b;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] r0;

    initial begin
        rstn = 1'b0; ext_data = 8'h00; ext_valid = 1'b0; cpu_rd = 1'b0;
        int_en = 1'b0; int_ack = 1'b0;
        @(posedge clk);
        #2;
        cyc(0, 8'h00, 0, 0);

        // 1 reset values
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_ready", {31'd0, ext_ready}, 32'd1);
        chk("rst_data", {24'd0, cpu_data}, 32'h00);
        chk("rst_int_req", {31'd0, int_req}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rstn = 1'b1;
        int_en = 1'b1;

        // 2 push, ack, drain, re-arm
        cyc(1, 8'hA5, 0, 0);
        chk("t2_data", {24'd0, cpu_data}, 32'hA5);
        chk("t2_req", {31'd0, int_req}, 32'd1);
        cyc(0, 8'h00, 0, 1);
        chk("t2_ack", {31'd0, int_req}, 32'd0);
        cyc(0, 8'h00, 1, 0);
        chk("t2_pop_empty", {31'd0, empty}, 32'd1);
        chk("t2_hold", {24'd0, cpu_data}, 32'hA5);
        cyc(1, 8'h5A, 0, 0);
        chk("t2_rearm", {31'd0, int_req}, 32'd1);
        cyc(0, 8'h00, 1, 1);
        cyc(0, 8'h00, 0, 0);
        chk("t2_clean", {31'd0, int_req}, 32'd0);

        // 3 fill, overflow, ordered drain
        for (int i = 1; i <= 4; i++) cyc(1, 8'(i * 8'h11), 0, 0);
        chk("t3_full", {31'd0, full}, 32'd1);
        chk("t3_ready", {31'd0, ext_ready}, 32'd0);
        cyc(1, 8'h55, 0, 0);
        chk("t3_ovf", {31'd0, ovf}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            exp_b = 8'(i * 8'h11);
            chk("t3_order", {24'd0, cpu_data}, {24'd0, exp_b});
            cyc(0, 8'h00, 1, 0);
        end
        chk("t3_empty", {31'd0, empty}, 32'd1);
        chk("t3_last", {24'd0, cpu_data}, 32'h44);
        chk("t3_withdrawn", {31'd0, int_req}, 32'd0);

        // 4 wrap twice, then streaming push+pop at constant occupancy
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) cyc(1, 8'(8'h80 + r * 4 + i), 0, 0);
            for (int i = 0; i < 4; i++) begin
                exp_b = 8'(8'h80 + r * 4 + i);
                chk("t4_wrap", {24'd0, cpu_data}, {24'd0, exp_b});
                cyc(0, 8'h00, 1, 0);
            end
        end
        cyc(1, 8'h60, 0, 0);
        for (int i = 0; i < 6; i++) begin
            exp_b = 8'(8'h60 + i);
            chk("t4_stream", {24'd0, cpu_data}, {24'd0, exp_b});
            cyc(1, 8'(8'h61 + i), 1, 0);
            chk("t4_count", {30'd0, empty, full}, 32'd0);
        end
        chk("t4_tail", {24'd0, cpu_data}, 32'h66);
        cyc(0, 8'h00, 1, 0);

        // 5 read while empty is ignored
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        chk("t5_empty", {31'd0, empty}, 32'd1);
        chk("t5_hold", {24'd0, cpu_data}, 32'h66);
        cyc(1, 8'h77, 0, 0);
        chk("t5_read", {24'd0, cpu_data}, 32'h77);
        cyc(0, 8'h00, 1, 0);

        // 6 reset mid-operation, then a CPU-style read/add sequence
        for (int i = 1; i <= 3; i++) cyc(1, 8'(i), 0, 0);
        chk("t6_pre_req", {31'd0, int_req}, 32'd1);
        rstn = 1'b0;
        cyc(0, 8'h00, 0, 0);
        chk("t6_empty", {31'd0, empty}, 32'd1);
        chk("t6_data", {24'd0, cpu_data}, 32'h00);
        chk("t6_req", {31'd0, int_req}, 32'd0);
        chk("t6_ovf", {31'd0, ovf}, 32'd0);
        rstn = 1'b1;
        cyc(1, 8'h01, 0, 0);
        cyc(1, 8'h02, 0, 0);
        b1 = cpu_data;
        cyc(0, 8'h00, 1, 1);
        b2 = cpu_data;
        cyc(0, 8'h00, 1, 0);
        r0 = b1 + b2;
        chk("t6_add", {24'd0, r0}, 32'h03);
        cyc(0, 8'h00, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
